// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the 4-way round-robin mux arbiter: state encoding,
// requester count, select/data widths and the round-robin priority search.
package mux4_rr_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;
    localparam int DATA_W  = 2;

    // Return the first requester set in the order ptr+1, ptr+2, ptr+3, ptr.
    // Only meaningful when req is non-zero; otherwise ptr is returned.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [SEL_W-1:0]   ptr);
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] pick;
        logic             found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = ptr + SEL_W'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_sel2.sv
// Purely combinational 4:1 mux of 2-bit words steered by the arbiter select.
module mux4_sel2
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [1:0] s,
    input  logic [1:0] d0,
    input  logic [1:0] d1,
    input  logic [1:0] d2,
    input  logic [1:0] d3,
    output logic [1:0] y
);

    // Select one of the four requester words.
    always_comb begin
        y = d0;
        case (s)
            2'd0: y = d0;
            2'd1: y = d1;
            2'd2: y = d2;
            2'd3: y = d3;
            default: y = d0;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 select mux among four requesters.
// A grant lasts while the owner keeps requesting, up to MAX_HOLD cycles, and
// every grant is followed by at least one idle cycle before re-arbitration.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [1:0] d0,
    input  logic [1:0] d1,
    input  logic [1:0] d2,
    input  logic [1:0] d3,
    output logic [3:0] gnt,
    output logic [1:0] s,
    output logic       busy,
    output logic [1:0] y,
    output logic       y_valid
);

    state_t              state;
    state_t              state_next;
    logic [NUM_REQ-1:0]  gnt_next;
    logic [SEL_W-1:0]    s_next;
    logic                busy_next;
    logic [SEL_W-1:0]    ptr;
    logic [SEL_W-1:0]    ptr_next;
    logic [7:0]          hold_cnt;
    logic [7:0]          hold_next;
    logic [DATA_W-1:0]   word_p0;
    logic                owner_req;
    logic                hold_done;

    // Hold counter advances by one but sticks at MAX_HOLD instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
        if (cnt >= 8'(MAX_HOLD))
            return 8'(MAX_HOLD);
        else
            return cnt + 8'd1;
    endfunction

    mux4_sel2 u_sel (
        .s  (s),
        .d0 (d0),
        .d1 (d1),
        .d2 (d2),
        .d3 (d3),
        .y  (word_p0)
    );

    // In GRANT the registered select always names the current owner.
    assign owner_req = req[s];
    assign hold_done = (hold_cnt == 8'(MAX_HOLD));

    // Next-state logic: arbitrate only in IDLE, release on drop or hold limit.
    always_comb begin
        state_next = state;
        gnt_next   = gnt;
        s_next     = s;
        busy_next  = busy;
        ptr_next   = ptr;
        hold_next  = hold_cnt;
        case (state)
            IDLE: begin
                gnt_next  = '0;
                busy_next = 1'b0;
                if (|req) begin
                    s_next     = rr_pick(req, ptr);
                    gnt_next   = NUM_REQ'(1) << rr_pick(req, ptr);
                    busy_next  = 1'b1;
                    hold_next  = 8'd1;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (!owner_req || hold_done) begin
                    state_next = IDLE;
                    gnt_next   = '0;
                    busy_next  = 1'b0;
                    ptr_next   = s;
                end else begin
                    hold_next = sat_inc(hold_cnt);
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
                busy_next  = 1'b0;
            end
        endcase
    end

    // Control registers; reset wins over every other condition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            s        <= '0;
            busy     <= 1'b0;
            ptr      <= 2'd3;
            hold_cnt <= 8'd0;
        end else begin
            state    <= state_next;
            gnt      <= gnt_next;
            s        <= s_next;
            busy     <= busy_next;
            ptr      <= ptr_next;
            hold_cnt <= hold_next;
        end
    end

    // Output stage: register the muxed word and flag it when the owner requested.
    always_ff @(posedge clk) begin
        if (rst) begin
            y       <= '0;
            y_valid <= 1'b0;
        end else begin
            y       <= word_p0;
            y_valid <= |(gnt & req);
        end
    end

endmodule
